joy_mdscan_sequencer: RTL and testbench

Frame-rate scheduler for the serial joystick shift-register reader. It drives the Megadrive select line through an 8-phase sequence per poll frame and requests 16-bit serial reads from the reader at the phases that matter. It decodes 3- and 6-button pads for two ports and commits atomically updated, active-high button vectors to the core. It sits between the board joystick reader and the core's keyboard/joystick mapping logic.

---
 rtl/joy_mdscan_sequencer.sv | 195 +++++++++++++++++++
 tb/tb_joy_mdscan_sequencer.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/joy_mdscan_sequencer.sv
// joy_mdscan_sequencer: frame-rate Megadrive pad poll sequencer driving joy_sel and requesting serial reads
//   clk, reset (async, active-high), scan_en       : clock, reset, enable poll frames
//   joy_sel                                        : select line to the connector (1 while idle)
//   rd_start / rd_valid / rd_data[15:0]            : request / response of one 16-bit active-low serial read
//   pad1_btn[11:0], pad2_btn[11:0], pad_is6[1:0]   : committed active-high buttons and 6-button flags
//   frame_done, rd_err                             : commit pulse, sticky read-timeout flag
//   JOYSCAN_AUTOFIRE_EN (optional macro)           : adds autofire[1:0] input gating button A per pad
module joy_mdscan_sequencer #(
  parameter int FRAME_DIV = 20000,
  parameter int SETTLE = 32,
  parameter int RD_TIMEOUT = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        scan_en,
  output logic        joy_sel,
  output logic        rd_start,
  input  logic        rd_valid,
  input  logic [15:0] rd_data,
`ifdef JOYSCAN_AUTOFIRE_EN
  input  logic [1:0]  autofire,
`endif
  output logic [11:0] pad1_btn,
  output logic [11:0] pad2_btn,
  output logic [1:0]  pad_is6,
  output logic        frame_done,
  output logic        rd_err
);
  localparam int TMAX = (SETTLE > RD_TIMEOUT) ? SETTLE : RD_TIMEOUT;
  localparam int TW = $clog2(TMAX + 1);
  localparam int DW = $clog2(FRAME_DIV + 1);
  typedef enum logic [2:0] {S_IDLE, S_SETTLE, S_RD_REQ, S_RD_WAIT, S_COMMIT} state_t;
  state_t state_q, state_d;
  logic [2:0] phase_q, phase_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic [DW-1:0] div_q, div_d;
  logic sel_q, sel_d;
  logic rd_start_q, rd_start_d;
  logic done_q, done_d;
  logic err_q, err_d;
  logic [11:0] btn1_q, btn1_d, btn2_q, btn2_d;
  logic [11:0] sh1_q, sh1_d, sh2_q, sh2_d;
  logic [1:0] is6_q, is6_d, sh_is6_q, sh_is6_d;
  logic [1:0] a_gate;
  logic tick, settled, timed_out, rd_phase;
  logic unused_rd_bits;
`ifdef JOYSCAN_AUTOFIRE_EN
  logic [2:0] fc_q, fc_d;
  assign a_gate = ~autofire | {2{fc_q[2]}};
`else
  assign a_gate = 2'b11;
`endif
  // f3 and start-position bits carry nothing in the decoded phases
  assign unused_rd_bits = ^{rd_data[9:8], rd_data[1:0]};
  assign tick = div_q == DW'(FRAME_DIV - 1);
  assign settled = tmr_q == TW'(SETTLE - 1);
  assign timed_out = tmr_q == TW'(RD_TIMEOUT - 1);
  assign rd_phase = phase_q inside {3'd0, 3'd1, 3'd5, 3'd6};
  // Merge one read phase of one pad into its shadow button vector
  function automatic logic [11:0] capture(input logic [11:0] b, input logic [2:0] ph,
                                          input logic [7:0] raw, input logic six);
    logic [7:0] d;
    d = ~raw;
    capture = ph == 3'd0 ? {b[11:7], d[2], d[3], b[4], d[4], d[5], d[6], d[7]} :
              ph == 3'd1 ? {b[11:8], d[2], b[6:5], d[3], b[3:0]} :
              ph == 3'd6 ? {six ? {d[4], d[7], d[6], d[5]} : 4'b0, b[7:0]} : b;
  endfunction
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    tmr_d = tmr_q;
    sel_d = sel_q;
    rd_start_d = 1'b0;
    done_d = 1'b0;
    err_d = err_q;
    btn1_d = btn1_q;
    btn2_d = btn2_q;
    is6_d = is6_q;
    sh1_d = sh1_q;
    sh2_d = sh2_q;
    sh_is6_d = sh_is6_q;
`ifdef JOYSCAN_AUTOFIRE_EN
    fc_d = fc_q;
`endif
    div_d = tick ? '0 : div_q + 1'b1;
    unique case (state_q)
      S_IDLE: begin
        tmr_d = '0;
        // ticks arriving outside IDLE are simply lost
        if (tick && scan_en) begin
          state_d = S_SETTLE;
          phase_d = 3'd0;
          sel_d = 1'b1;
          sh1_d = '0;
          sh2_d = '0;
          sh_is6_d = '0;
        end
      end
      S_SETTLE: begin
        tmr_d = settled ? '0 : tmr_q + 1'b1;
        if (settled) begin
          if (rd_phase) begin
            state_d = S_RD_REQ;
            rd_start_d = 1'b1;
          end else if (phase_q == 3'd7) begin
            state_d = S_COMMIT;
          end else begin
            phase_d = phase_q + 3'd1;
            sel_d = ~sel_q;
          end
        end
      end
      S_RD_REQ: begin
        state_d = S_RD_WAIT;
        tmr_d = '0;
      end
      S_RD_WAIT: begin
        tmr_d = tmr_q + 1'b1;
        if (rd_valid) begin
          tmr_d = '0;
          state_d = S_SETTLE;
          phase_d = phase_q + 3'd1;
          sel_d = ~sel_q;
          sh1_d = capture(sh1_q, phase_q, rd_data[7:0], sh_is6_q[0]);
          sh2_d = capture(sh2_q, phase_q, rd_data[15:8], sh_is6_q[1]);
          sh_is6_d = phase_q == 3'd5 ? {rd_data[15:12] == 4'h0, rd_data[7:4] == 4'h0} : sh_is6_q;
        end else if (timed_out) begin
          tmr_d = '0;
          state_d = S_IDLE;
          sel_d = 1'b1;
          err_d = 1'b1;
        end
      end
      S_COMMIT: begin
        btn1_d = {sh1_q[11:5], sh1_q[4] & a_gate[0], sh1_q[3:0]};
        btn2_d = {sh2_q[11:5], sh2_q[4] & a_gate[1], sh2_q[3:0]};
        is6_d = sh_is6_q;
        done_d = 1'b1;
        err_d = 1'b0;
        sel_d = 1'b1;
        state_d = S_IDLE;
`ifdef JOYSCAN_AUTOFIRE_EN
        fc_d = fc_q + 3'd1;
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      phase_q <= '0;
      tmr_q <= '0;
      div_q <= '0;
      sel_q <= 1'b1;
      rd_start_q <= 1'b0;
      done_q <= 1'b0;
      err_q <= 1'b0;
      btn1_q <= '0;
      btn2_q <= '0;
      is6_q <= '0;
      sh1_q <= '0;
      sh2_q <= '0;
      sh_is6_q <= '0;
`ifdef JOYSCAN_AUTOFIRE_EN
      fc_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      tmr_q <= tmr_d;
      div_q <= div_d;
      sel_q <= sel_d;
      rd_start_q <= rd_start_d;
      done_q <= done_d;
      err_q <= err_d;
      btn1_q <= btn1_d;
      btn2_q <= btn2_d;
      is6_q <= is6_d;
      sh1_q <= sh1_d;
      sh2_q <= sh2_d;
      sh_is6_q <= sh_is6_d;
`ifdef JOYSCAN_AUTOFIRE_EN
      fc_q <= fc_d;
`endif
    end
  end
  assign joy_sel = sel_q;
  assign rd_start = rd_start_q;
  assign frame_done = done_q;
  assign rd_err = err_q;
  assign pad1_btn = btn1_q;
  assign pad2_btn = btn2_q;
  assign pad_is6 = is6_q;
endmodule

// File: tb/tb_joy_mdscan_sequencer.sv
// tb_joy_mdscan_sequencer: scoreboard bench with a behavioural pad decode model
module tb_joy_mdscan_sequencer;
  localparam int FRAME_DIV = 300;
  localparam int SETTLE = 4;
  localparam int RD_TIMEOUT = 16;
  localparam int WAIT_LIM = 2 * FRAME_DIV + 400;
  typedef logic [3:0][15:0] frame_t;
  typedef struct packed {
    logic [11:0] b1;
    logic [11:0] b2;
    logic [1:0]  six;
  } exp_t;
  logic clk = 0;
  logic reset = 0;
  logic scan_en = 0;
  logic rd_valid = 0;
  logic [15:0] rd_data = '0;
  logic joy_sel, rd_start, frame_done, rd_err;
  logic [11:0] pad1_btn, pad2_btn;
  logic [1:0] pad_is6;
`ifdef JOYSCAN_AUTOFIRE_EN
  logic [1:0] autofire = '0;
`endif
  exp_t exp_q[$];
  exp_t last = '0;
  exp_t mon_e;
  logic err_exp = 0;
  int vectors = 0;
  int miscompares = 0;
  int frames_done = 0;
  always #5 clk = ~clk;
  joy_mdscan_sequencer #(.FRAME_DIV(FRAME_DIV), .SETTLE(SETTLE), .RD_TIMEOUT(RD_TIMEOUT)) dut (
    .clk(clk),
    .reset(reset),
    .scan_en(scan_en),
    .joy_sel(joy_sel),
    .rd_start(rd_start),
    .rd_valid(rd_valid),
    .rd_data(rd_data),
`ifdef JOYSCAN_AUTOFIRE_EN
    .autofire(autofire),
`endif
    .pad1_btn(pad1_btn),
    .pad2_btn(pad2_btn),
    .pad_is6(pad_is6),
    .frame_done(frame_done),
    .rd_err(rd_err)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: actual %0h expected %0h", name, act, exp);
    end
  endtask
  // Reads 0..3 of a frame are the pad answers at select phases 0, 1, 5, 6
  function automatic exp_t model(input frame_t w);
    exp_t e;
    logic [1:0][11:0] b;
    logic [1:0] six;
    logic [7:0] r0, r1, r5, r6;
    for (int p = 0; p < 2; p++) begin
      r0 = w[0][8*p +: 8];
      r1 = w[1][8*p +: 8];
      r5 = w[2][8*p +: 8];
      r6 = w[3][8*p +: 8];
      b[p] = '0;
      b[p][0] = !r0[7];
      b[p][1] = !r0[6];
      b[p][2] = !r0[5];
      b[p][3] = !r0[4];
      b[p][5] = !r0[3];
      b[p][6] = !r0[2];
      b[p][4] = !r1[3];
      b[p][7] = !r1[2];
      six[p] = r5[7:4] == 4'h0;
      if (six[p]) begin
        b[p][10] = !r6[7];
        b[p][9] = !r6[6];
        b[p][8] = !r6[5];
        b[p][11] = !r6[4];
      end
    end
    e.b1 = b[0];
    e.b2 = b[1];
    e.six = six;
    return e;
  endfunction
  function automatic frame_t rand_frame();
    frame_t w;
    for (int k = 0; k < 4; k++) w[k] = 16'($urandom);
    if ($urandom_range(0, 1) == 1) w[2][7:4] = 4'h0;
    if ($urandom_range(0, 1) == 1) w[2][15:12] = 4'h0;
    return w;
  endfunction
  task automatic wait_rd(input int lim, output bit ok, output int n);
    ok = 0;
    n = 0;
    while (!ok && n < lim) begin
      @(negedge clk);
      n++;
      ok = rd_start;
    end
  endtask
  task automatic wait_done(input int target);
    int n;
    n = 0;
    while (frames_done < target && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("frame_done_seen", 32'(frames_done >= target), 1);
  endtask
  // Answers one frame's reads; drop = read index left unanswered (-1 none)
  task automatic run_frame(input frame_t w, input int drop, input bit stop, output int first_n);
    bit ok;
    int n;
    logic [3:0] sel_pat;
    sel_pat = 4'b1001;
    first_n = 0;
    for (int k = 0; k < 4; k++) begin
      wait_rd(WAIT_LIM, ok, n);
      if (k == 0) first_n = n;
      chk("rd_start_seen", 32'(ok), 1);
      if (!ok) return;
      chk("sel_at_read", 32'(joy_sel), 32'(sel_pat[k]));
      chk("rd_err_hold", 32'(rd_err), 32'(err_exp));
      @(negedge clk);
      chk("rd_start_pulse", 32'(rd_start), 0);
      if (k == drop) begin
        n = 1;
        while (!rd_err && n < RD_TIMEOUT + 40) begin
          @(negedge clk);
          n++;
        end
        chk("timeout_latency", n, RD_TIMEOUT + 1);
        chk("timeout_sel", 32'(joy_sel), 1);
        chk("timeout_hold_pad1", 32'(pad1_btn), 32'(last.b1));
        chk("timeout_hold_pad2", 32'(pad2_btn), 32'(last.b2));
        chk("timeout_hold_is6", 32'(pad_is6), 32'(last.six));
        err_exp = 1;
        return;
      end
      repeat ($urandom_range(0, 5)) @(negedge clk);
      rd_data = w[k];
      rd_valid = 1;
      @(negedge clk);
      rd_valid = 0;
      rd_data = 16'($urandom);
      if (stop && k == 1) scan_en = 0;
    end
    exp_q.push_back(model(w));
  endtask
  always @(negedge clk) begin
    if (!reset && frame_done) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_frame_done", 32'(frame_done), 0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("pad1_btn", 32'(pad1_btn), 32'(mon_e.b1));
        chk("pad2_btn", 32'(pad2_btn), 32'(mon_e.b2));
        chk("pad_is6", 32'(pad_is6), 32'(mon_e.six));
        chk("commit_rd_err", 32'(rd_err), 0);
        chk("commit_sel", 32'(joy_sel), 1);
        last = mon_e;
        err_exp = 0;
      end
      frames_done++;
    end
  end
  initial begin
    frame_t w;
    int n, tgt, rd_cnt, sel_bad, drop;
    bit ok;
    #3 reset = 1;
    repeat (3) @(negedge clk);
    chk("rst_pad1", 32'(pad1_btn), 0);
    chk("rst_pad2", 32'(pad2_btn), 0);
    chk("rst_is6", 32'(pad_is6), 0);
    chk("rst_sel", 32'(joy_sel), 1);
    chk("rst_rd_start", 32'(rd_start), 0);
    chk("rst_frame_done", 32'(frame_done), 0);
    chk("rst_rd_err", 32'(rd_err), 0);
    scan_en = 1;
    reset = 0;
    w = {4{16'hFFFF}};
    run_frame(w, -1, 0, n);
    chk("first_frame_window", 32'(n >= FRAME_DIV - 1 && n <= FRAME_DIV + SETTLE + 1), 1);
    w[0] = 16'hFF77;
    w[1] = 16'hFFC7;
    w[2] = 16'h0FCF;
    w[3] = 16'hAFFF;
    run_frame(w, -1, 0, n);
    run_frame(rand_frame(), 2, 0, n);
    run_frame(rand_frame(), -1, 0, n);
    for (int i = 0; i < 24; i++) begin
      drop = (!err_exp && $urandom_range(0, 5) == 0) ? int'($urandom_range(0, 3)) : -1;
      run_frame(rand_frame(), drop, 0, n);
    end
    run_frame(rand_frame(), -1, 1, n);
    tgt = frames_done + 1;
    wait_done(tgt);
    rd_cnt = 0;
    sel_bad = 0;
    repeat (3 * FRAME_DIV) begin
      @(negedge clk);
      rd_cnt += int'(rd_start);
      sel_bad += int'(!joy_sel);
    end
    chk("stopped_rd_starts", rd_cnt, 0);
    chk("stopped_sel_low", sel_bad, 0);
    scan_en = 1;
    run_frame(rand_frame(), -1, 0, n);
    run_frame(rand_frame(), -1, 0, n);
    wait_rd(WAIT_LIM, ok, n);
    chk("rd_start_before_reset", 32'(ok), 1);
    repeat (3) @(negedge clk);
    #2 reset = 1;
    #1;
    chk("arst_pad1", 32'(pad1_btn), 0);
    chk("arst_pad2", 32'(pad2_btn), 0);
    chk("arst_is6", 32'(pad_is6), 0);
    chk("arst_sel", 32'(joy_sel), 1);
    chk("arst_rd_start", 32'(rd_start), 0);
    chk("arst_rd_err", 32'(rd_err), 0);
    exp_q.delete();
    last = '0;
    err_exp = 0;
    @(negedge clk);
    repeat (2) @(negedge clk);
    reset = 0;
    run_frame(rand_frame(), -1, 0, n);
    chk("post_reset_window", 32'(n >= FRAME_DIV - 1 && n <= FRAME_DIV + SETTLE + 1), 1);
    run_frame(rand_frame(), -1, 0, n);
    tgt = frames_done + 1;
    wait_done(tgt);
    chk("scoreboard_drain", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
